// File: rtl/cache_miss_ctrl.sv
// Request sequencer in front of a direct-mapped cache: probes on loads, refills from
// memory on a miss, writes stores through to cache then memory, counts hits/misses.
module cache_miss_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_we,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
  output logic                  cpu_resp_valid,
  input  logic                  cpu_resp_ready,
  output logic [DATA_WIDTH-1:0] cpu_resp_data,
  output logic                  cpu_resp_miss,
  output logic                  cache_read_en,
  output logic                  cache_write_en,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_write_data,
  input  logic [DATA_WIDTH-1:0] cache_read_data,
  input  logic                  cache_hit,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  // state      | meaning
  // S_IDLE     | ready for a CPU request
  // S_LOOKUP   | cache probe strobe
  // S_CHECK    | cache hit/data valid, decide hit or miss
  // S_MEM_REQ  | line fetch request to memory
  // S_MEM_WAIT | waiting for fetched line
  // S_FILL     | write fetched line into cache
  // S_WR_CACHE | store: write cache
  // S_WR_MEM   | store: write-through request to memory
  // S_RESP     | response held until CPU accepts
  typedef enum logic [3:0] {
    S_IDLE, S_LOOKUP, S_CHECK, S_MEM_REQ, S_MEM_WAIT,
    S_FILL, S_WR_CACHE, S_WR_MEM, S_RESP
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic                  r_resp_miss;
  logic [CNT_WIDTH-1:0]  r_hit_cnt;
  logic [CNT_WIDTH-1:0]  r_miss_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_resp_data <= '0;
      r_resp_miss <= 1'b0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req_valid) begin
            r_addr  <= cpu_req_addr;
            r_wdata <= cpu_req_wdata;
            r_state <= cpu_req_we ? S_WR_CACHE : S_LOOKUP;
          end
        end
        S_LOOKUP: r_state <= S_CHECK;
        S_CHECK: begin
          if (cache_hit) begin
            r_resp_data <= cache_read_data;
            r_resp_miss <= 1'b0;
            if (r_hit_cnt != CNT_MAX) r_hit_cnt <= r_hit_cnt + 1'b1;
            r_state     <= S_RESP;
          end else begin
            if (r_miss_cnt != CNT_MAX) r_miss_cnt <= r_miss_cnt + 1'b1;
            r_state     <= S_MEM_REQ;
          end
        end
        S_MEM_REQ: begin
          if (mem_req_ready) r_state <= S_MEM_WAIT;
        end
        // The fetched line is parked in the response register; FILL writes it from there.
        S_MEM_WAIT: begin
          if (mem_resp_valid) begin
            r_resp_data <= mem_resp_data;
            r_state     <= S_FILL;
          end
        end
        S_FILL: begin
          r_resp_miss <= 1'b1;
          r_state     <= S_RESP;
        end
        S_WR_CACHE: r_state <= S_WR_MEM;
        S_WR_MEM: begin
          if (mem_req_ready) begin
            r_resp_data <= '0;
            r_resp_miss <= 1'b0;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (cpu_resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_req_ready    = (r_state == S_IDLE);
  assign cpu_resp_valid   = (r_state == S_RESP);
  assign cpu_resp_data    = r_resp_data;
  assign cpu_resp_miss    = r_resp_miss;
  assign cache_read_en    = (r_state == S_LOOKUP);
  assign cache_write_en   = (r_state == S_FILL) || (r_state == S_WR_CACHE);
  assign cache_addr       = r_addr;
  assign cache_write_data = (r_state == S_FILL) ? r_resp_data : r_wdata;
  assign mem_req_valid    = (r_state == S_MEM_REQ) || (r_state == S_WR_MEM);
  assign mem_req_we       = (r_state == S_WR_MEM);
  assign mem_req_addr     = r_addr;
  assign mem_req_wdata    = r_wdata;
  assign hit_count        = r_hit_cnt;
  assign miss_count       = r_miss_cnt;

endmodule

// File: doc/cache_miss_ctrl.md
# cache_miss_ctrl

Sequencer in front of the direct-mapped cache.
- Accepts one CPU load/store at a time and probes the cache on loads.
- On a load miss, fetches the line from the memory port, writes it into the cache, then returns it.
- Stores are write-through: cache first, then memory.
- Keeps saturating hit/miss counters for performance monitoring.

## Interface
- ADDR_WIDTH, 32, address width (matches cache)
- DATA_WIDTH, 128, line/data width (matches cache)
- CNT_WIDTH, 16, width of hit/miss counters
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (sampled on posedge clk; low = reset)
- cpu_req_valid  in  1  CPU request valid
- cpu_req_ready  out  1  controller can accept request (high only in IDLE)
- cpu_req_we  in  1  1 = store, 0 = load
- cpu_req_addr  in  ADDR_WIDTH  request address
- cpu_req_wdata  in  DATA_WIDTH  store data
- cpu_resp_valid  out  1  response valid, held until cpu_resp_ready
- cpu_resp_ready  in  1  CPU accepts response
- cpu_resp_data  out  DATA_WIDTH  load data; 0 for stores
- cpu_resp_miss  out  1  1 if the load was served from memory; 0 for hits and stores
- cache_read_en  out  1  cache probe strobe
- cache_write_en  out  1  cache write strobe
- cache_addr  out  ADDR_WIDTH  cache address (latched request address)
- cache_write_data  out  DATA_WIDTH  cache write data
- cache_read_data  in  DATA_WIDTH  cache data, registered one cycle after cache_read_en
- cache_hit  in  1  cache hit flag, registered one cycle after cache_read_en
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = write-through store, 0 = line fetch
- mem_req_addr  out  ADDR_WIDTH  memory address
- mem_req_wdata  out  DATA_WIDTH  store data to memory
- mem_resp_valid  in  1  fetch data valid (single-cycle pulse)
- mem_resp_data  in  DATA_WIDTH  fetched line
- hit_count  out  CNT_WIDTH  load hits since reset, saturating
- miss_count  out  CNT_WIDTH  load misses since reset, saturating

## Operation
- States: IDLE, LOOKUP, CHECK, MEM_REQ, MEM_WAIT, FILL, WR_CACHE, WR_MEM, RESP.
- Request latching: on acceptance (cpu_req_valid & cpu_req_ready), latch addr, we and wdata; CPU inputs are ignored until the next IDLE.
- IDLE: cpu_req_ready=1. On accept, a load goes to LOOKUP and a store goes to WR_CACHE.
- LOOKUP: cache_read_en=1 with cache_addr = latched addr. Go to CHECK.
- CHECK: sample cache_hit.
  - Hit: capture cache_read_data, resp_miss=0, hit_count+1, go to RESP.
  - Miss: miss_count+1, go to MEM_REQ.
- MEM_REQ: mem_req_valid=1, mem_req_we=0, mem_req_addr = latched addr. Hold until mem_req_ready; on handshake go to MEM_WAIT.
- MEM_WAIT: on mem_resp_valid, capture mem_resp_data and go to FILL. mem_resp_valid seen in any other state is ignored.
- FILL: cache_write_en=1 with the captured data. resp_miss=1. Go to RESP.
- WR_CACHE: cache_write_en=1, cache_write_data = latched wdata. Go to WR_MEM.
- WR_MEM: mem_req_valid=1, mem_req_we=1, mem_req_wdata = latched wdata. On mem_req_ready, response data=0 and go to RESP. No memory response is expected for stores.
- RESP: cpu_resp_valid=1 and data/miss stable. On cpu_resp_ready go to IDLE. The next request can be accepted no earlier than the cycle after the response handshake.
- Strobe rules: cache_read_en and cache_write_en are never asserted together; each is high for exactly one cycle per use.
- Counters: saturate at 2^CNT_WIDTH-1 (no wrap). Stores do not count.

## Timing
- Reset: when reset=0 at posedge clk, the next state is IDLE.
  - All outputs go to 0: cpu_resp_valid, mem_req_valid, both strobes, cpu_resp_data, cpu_resp_miss, hit_count, miss_count.
  - cpu_req_ready is 1 once out of reset.
- Reset mid-operation: an in-flight transaction is dropped without a response. An outstanding memory fetch is abandoned, and its later mem_resp_valid is ignored.
- Cache probe: the cache registers hit/data one cycle after cache_read_en.
- Load hit, accept at edge N:
  - LOOKUP in cycle N+1.
  - CHECK in N+2.
  - cpu_resp_valid high from cycle N+3.
- Load miss, with mem_req_ready high immediately and mem_resp_valid k cycles after the request handshake:
  - FILL follows the mem_resp_valid cycle.
  - cpu_resp_valid rises the cycle after FILL.
- Store, with mem_req_ready high immediately: cpu_resp_valid high from cycle N+3.
- Handshakes: mem_req_valid and cpu_resp_valid never drop before their ready, and payload is stable while valid is high.
- Output registration: all outputs are registered or decoded from the state register only. There is no combinational path from CPU or memory inputs to any output.

## Test plan
- Reset: hold reset=0 for 3 cycles mid-miss (in MEM_WAIT), release, then inject mem_resp_valid -> no cpu_resp_valid; cpu_req_ready=1; counters 0.
- Load miss then hit:
  - Load 0x40 with cache empty; memory returns 0xDEAD_BEEF after 4 cycles -> cpu_resp_data=0xDEADBEEF, cpu_resp_miss=1, one cache_write_en at addr 0x40, miss_count=1.
  - Reload 0x40 -> resp at N+3, cpu_resp_miss=0, hit_count=1, no mem_req_valid.
- Store: store 0x80, data 0x1234, with mem_req_ready held low for 5 cycles -> cache_write_en once, mem_req_valid held 5+ cycles with we=1 and stable payload; resp data=0; a load of 0x80 then hits with 0x1234.
- Response backpressure: cpu_resp_ready low for 10 cycles -> cpu_resp_valid and data stable; cpu_req_ready=0; a new cpu_req_valid is not accepted.
- Counter saturation: CNT_WIDTH=4, 20 load hits -> hit_count stops at 15.
- Stray memory response: mem_resp_valid pulsed while in IDLE and LOOKUP -> no state change, no cache write.
